// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch stage. Owns the PC and issues in-order fetch requests to
// instruction memory over a req/gnt/rvalid handshake. Returned words are
// paired with the PC that fetched them and buffered in a small prefetch FIFO.
// The head of that FIFO feeds the IF/ID pipeline register.
//
// A redirect from EX (taken branch/jump/exception) restarts fetch at a new PC.
// It also throws away every buffered word and every word still in flight.
// In-flight words cannot be recalled from memory, so they are counted and
// silently dropped as they arrive.
//
// Parameters
//   RESET_PC    PC loaded on reset
//   FIFO_DEPTH  prefetch FIFO entries (power of 2, >= 2); also the cap on
//               outstanding plus buffered fetches
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   stall           IF/ID not accepting, FIFO head is held
//   redirect_valid  single-cycle redirect pulse
//   redirect_pc     new fetch PC (bits [1:0] ignored)
//   imem_req/addr   fetch request and word-aligned address
//   imem_gnt        request accepted when imem_req && imem_gnt
//   imem_rvalid     in-order response valid, imem_rdata carries the word
//   if_valid        FIFO head is a valid instruction
//   if_pc/if_instr  PC and word of the FIFO head (0 when empty)
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_S = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic [PW-1:0] fifo_rd;
  logic [PW-1:0] fifo_wr;
  logic [PW-1:0] pq_rd;
  logic [PW-1:0] pq_wr;

  logic [31:0] fifo_pc    [FIFO_DEPTH];
  logic [31:0] fifo_instr [FIFO_DEPTH];
  logic [31:0] pq_pc      [FIFO_DEPTH];

  logic grant;
  logic resp_keep;
  logic push;
  logic pop;
  logic fifo_empty;
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Words in flight count against the FIFO space they will need on arrival.
  // Stale words still being discarded count too, so this cap is also a bound
  // on the discard counter.
  assign imem_req = !rst && !redirect_valid &&
                    (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_S);
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;

  // A response is kept only when no stale words are still pending.
  assign resp_keep  = imem_rvalid && (discard == '0);
  assign push       = resp_keep && !redirect_valid;
  assign fifo_empty = (fifo_count == '0);
  assign if_valid   = !fifo_empty && !redirect_valid;
  assign pop        = if_valid && !stall;
  assign if_pc      = fifo_empty ? 32'h0 : fifo_pc[fifo_rd];
  assign if_instr   = fifo_empty ? 32'h0 : fifo_instr[fifo_rd];

  always_comb begin
    outstanding_nxt = outstanding;
    if (grant) begin
      outstanding_nxt = outstanding_nxt + CW'(1);
    end
    if (imem_rvalid) begin
      outstanding_nxt = outstanding_nxt - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      fifo_rd     <= '0;
      fifo_wr     <= '0;
      pq_rd       <= '0;
      pq_wr       <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        // Everything still in flight after this cycle is stale. A response
        // arriving now has left flight whether it was kept or dropped, so
        // outstanding_nxt is the right count even for back-to-back redirects.
        pc         <= {redirect_pc[31:2], 2'b00};
        discard    <= outstanding_nxt;
        fifo_count <= '0;
        fifo_rd    <= '0;
        fifo_wr    <= '0;
        pq_rd      <= '0;
        pq_wr      <= '0;
      end else begin
        if (grant) begin
          pc    <= pc + 32'd4;
          pq_wr <= pq_wr + PW'(1);
        end
        // Stale responses have no PC queue entry; the queue was cleared on redirect.
        if (resp_keep) begin
          pq_rd <= pq_rd + PW'(1);
        end else if (imem_rvalid) begin
          discard <= discard - CW'(1);
        end
        if (push) begin
          fifo_wr <= fifo_wr + PW'(1);
        end
        if (pop) begin
          fifo_rd <= fifo_rd + PW'(1);
        end
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + CW'(1);
          2'b01:   fifo_count <= fifo_count - CW'(1);
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

  // Storage needs no reset; validity is tracked by the counters and pointers.
  always_ff @(posedge clk) begin
    if (grant) begin
      pq_pc[pq_wr] <= pc;
    end
    if (push) begin
      fifo_pc[fifo_wr]    <= pq_pc[pq_rd];
      fifo_instr[fifo_wr] <= imem_rdata;
    end
  end

endmodule
